w_stage: RTL and testbench
==========================

# w_stage

Writeback stage of the five-stage MIPS pipeline: the M/W pipeline register plus the writeback datapath. It captures the memory-stage instruction each cycle, extends raw data-memory words for sub-word loads, selects the final write-back value, and drives the register file's write port (address and data) and the W-stage forwarding tuple. It also keeps a retired-instruction counter for trace and debug.

## Interface
Parameters:
- `RETIRE_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `m_valid`  in  1  M stage holds a real instruction (0 = bubble)
- `m_flush`  in  1  kill the M-stage instruction (exception/interrupt); captured as a bubble
- `m_pc`  in  32  PC of the M-stage instruction
- `m_a3`  in  5  destination register number (0 = no write)
- `m_wd_sel`  in  3  write-data source select
- `m_load_type`  in  3  load extension type
- `m_addr_lo`  in  2  low two bits of the load byte address
- `m_alu_res`  in  32  ALU result
- `m_mem_rdata`  in  32  raw aligned word from data memory
- `m_hilo`  in  32  HI/LO read value
- `m_cp0_rdata`  in  32  CP0 read value
- `grf_a3`  out  5  register-file write address
- `grf_wd`  out  32  register-file write data
- `w_valid`  out  1  W stage holds a real instruction
- `w_pc`  out  32  PC of the W-stage instruction
- `retire_cnt`  out  RETIRE_W  count of instructions retired since reset

## Operation
- Every rising edge: if `reset`, clear all W registers. Else capture all `m_*` inputs; `w_valid` <= `m_valid & ~m_flush`. No stall input; the W stage never stalls.
- Flushed or invalid capture: `w_valid`=0 and the stored `a3` is forced to 0, so no register is written.
- `grf_a3` = stored `a3` when `w_valid`, else 0. `grf_wd` is combinational from W registers.
- Write-data select (`m_wd_sel`): 0 ALU, 1 MEM (extended load), 2 PC+8 (`w_pc` + 8, mod 2^32), 3 HILO, 4 CP0; codes 5–7 select ALU.
- Load extension (`m_load_type`): 0 LW, whole word; 1 LB, byte `addr_lo`, sign-extended; 2 LBU, same byte, zero-extended; 3 LH, halfword `addr_lo[1]` (0 = bits 15:0, 1 = bits 31:16), sign-extended; 4 LHU, same halfword, zero-extended; codes 5–7 behave as LW. Byte n = bits 8n+7:8n (little-endian). `addr_lo[0]` is ignored for halfwords; misalignment is trapped upstream.
- `grf_a3`=0 with nonzero `grf_wd` is legal. The register file discards writes to $0.
- `retire_cnt` increments by 1 at each edge where `w_valid`=1 and `reset`=0, and wraps modulo 2^RETIRE_W.

## Timing
- Latency: one cycle. An instruction present at M on edge k drives `grf_a3`/`grf_wd` during cycle k→k+1, and the register file commits it on edge k+1.
- `grf_wd` and `grf_a3` are valid the same cycle as `w_valid`. They serve as the W-stage forwarding source, and the register file's internal write-through also returns them to D.
- Reset values: `w_valid`=0, `w_pc`=0, `grf_a3`=0, `grf_wd`=0, `retire_cnt`=0.
- Reset asserted mid-stream: the W contents are discarded on that edge, with no write in the following cycle and no retire count for it.
- `m_flush` and `m_valid` both 1 on the same edge: flush wins.
- `retire_cnt` counts the instruction that occupies W during a cycle on the edge that ends that cycle.

## Structure
- Shared package `w_pkg`: `LOAD_LW/LB/LBU/LH/LHU` (3-bit) and `WD_ALU/MEM/PC8/HILO/CP0` (3-bit) constants. The M-stage controller uses the same package.
- One combinational sub-module `load_ext` takes (`rdata`, `addr_lo`, `load_type`) and returns the 32-bit extended value. The rest is the pipeline register, the select mux and the counter.

## Test plan
- Reset for 2 cycles, then idle: `grf_a3`=0, `grf_wd`=0, `w_valid`=0, `retire_cnt`=0.
- `m_valid`=1, `m_a3`=8, `wd_sel`=ALU, `alu_res`=0x12345678: the next cycle gives `grf_a3`=8, `grf_wd`=0x12345678, `w_valid`=1, and `retire_cnt` becomes 1 after the following edge.
- `mem_rdata`=0x80FF7F01, `wd_sel`=MEM, sweeping load types and `addr_lo`: LB@0=0x00000001, LB@1=0x0000007F, LB@2=0xFFFFFFFF, LBU@3=0x00000080, LH@0=0x00007F01, LH@2=0xFFFF80FF, LHU@2=0x000080FF, LW=0x80FF7F01.
- `wd_sel`=PC8 with `m_pc`=0x00003000 gives `grf_wd`=0x00003008. With `m_pc`=0xFFFFFFFC it gives 0x00000004.
- `m_valid`=1, `m_flush`=1, `m_a3`=5: next cycle `grf_a3`=0, `w_valid`=0, and `retire_cnt` is unchanged. Reset asserted while `w_valid`=1: `grf_a3`=0 on the next cycle.
- With `RETIRE_W`=4, retire 17 back-to-back valid instructions: `retire_cnt`=1.

Source files
------------

// File: rtl/w_pkg.sv
// Shared writeback-stage encodings: load extension types and write-data sources.
// No logic, so no latency.
// No flow control; these constants are also used by the M-stage controller.
package w_pkg;

    // Load extension types carried in m_load_type
    localparam logic [2:0] LOAD_LW  = 3'd0;
    localparam logic [2:0] LOAD_LB  = 3'd1;
    localparam logic [2:0] LOAD_LBU = 3'd2;
    localparam logic [2:0] LOAD_LH  = 3'd3;
    localparam logic [2:0] LOAD_LHU = 3'd4;

    // Write-data sources carried in m_wd_sel
    localparam logic [2:0] WD_ALU  = 3'd0;
    localparam logic [2:0] WD_MEM  = 3'd1;
    localparam logic [2:0] WD_PC8  = 3'd2;
    localparam logic [2:0] WD_HILO = 3'd3;
    localparam logic [2:0] WD_CP0  = 3'd4;

    // Contents of the M/W pipeline register
    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  a3;
        logic [2:0]  wd_sel;
        logic [2:0]  load_type;
        logic [1:0]  addr_lo;
        logic [31:0] alu_res;
        logic [31:0] mem_rdata;
        logic [31:0] hilo;
        logic [31:0] cp0_rdata;
    } w_regs_t;

endpackage

// File: rtl/load_ext.sv
// Extends a raw aligned data-memory word according to the load type and address.
// Purely combinational, zero cycles.
// No flow control.
module load_ext
    import w_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  load_type,
    output logic [31:0] ext
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Pick the addressed byte (little-endian) and halfword; addr_lo[0] is ignored for halfwords
    always_comb begin
        sel_byte = rdata[7:0];
        case (addr_lo)
            2'd0: sel_byte = rdata[7:0];
            2'd1: sel_byte = rdata[15:8];
            2'd2: sel_byte = rdata[23:16];
            2'd3: sel_byte = rdata[31:24];
            default: sel_byte = rdata[7:0];
        endcase
        sel_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    // Sign- or zero-extend the selection; unknown types act as a full-word load
    always_comb begin
        ext = rdata;
        case (load_type)
            LOAD_LB:  ext = {{24{sel_byte[7]}}, sel_byte};
            LOAD_LBU: ext = {24'd0, sel_byte};
            LOAD_LH:  ext = {{16{sel_half[15]}}, sel_half};
            LOAD_LHU: ext = {16'd0, sel_half};
            default:  ext = rdata;
        endcase
    end

endmodule

// File: rtl/w_stage.sv
// Writeback stage: M/W pipeline register, load extension, write-data mux, retire counter.
// One cycle from M capture to register-file write port / forwarding outputs.
// Never stalls; every edge captures M, flushed or invalid entries become bubbles.
module w_stage
    import w_pkg::*;
#(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                m_valid,
    input  logic                m_flush,
    input  logic [31:0]         m_pc,
    input  logic [4:0]          m_a3,
    input  logic [2:0]          m_wd_sel,
    input  logic [2:0]          m_load_type,
    input  logic [1:0]          m_addr_lo,
    input  logic [31:0]         m_alu_res,
    input  logic [31:0]         m_mem_rdata,
    input  logic [31:0]         m_hilo,
    input  logic [31:0]         m_cp0_rdata,
    output logic [4:0]          grf_a3,
    output logic [31:0]         grf_wd,
    output logic                w_valid,
    output logic [31:0]         w_pc,
    output logic [RETIRE_W-1:0] retire_cnt
);

    w_regs_t     w_q;
    logic        m_live;
    logic [31:0] mem_ext;
    logic [31:0] pc8;

    assign m_live = m_valid & ~m_flush;

    // Capture the M-stage instruction every edge; a bubble never carries a destination register
    always_ff @(posedge clk) begin
        if (reset) begin
            w_valid <= 1'b0;
            w_q     <= '0;
        end else begin
            w_valid         <= m_live;
            w_q.pc          <= m_pc;
            w_q.a3          <= m_live ? m_a3 : 5'd0;
            w_q.wd_sel      <= m_wd_sel;
            w_q.load_type   <= m_load_type;
            w_q.addr_lo     <= m_addr_lo;
            w_q.alu_res     <= m_alu_res;
            w_q.mem_rdata   <= m_mem_rdata;
            w_q.hilo        <= m_hilo;
            w_q.cp0_rdata   <= m_cp0_rdata;
        end
    end

    // Count the instruction leaving W at the end of each cycle it occupied
    always_ff @(posedge clk) begin
        if (reset) begin
            retire_cnt <= '0;
        end else if (w_valid) begin
            retire_cnt <= retire_cnt + {{(RETIRE_W-1){1'b0}}, 1'b1};
        end
    end

    load_ext u_load_ext (
        .rdata     (w_q.mem_rdata),
        .addr_lo   (w_q.addr_lo),
        .load_type (w_q.load_type),
        .ext       (mem_ext)
    );

    assign pc8 = w_q.pc + 32'd8;

    // Select the write-back value; unused select codes fall back to the ALU result
    always_comb begin
        grf_wd = w_q.alu_res;
        case (w_q.wd_sel)
            WD_ALU:  grf_wd = w_q.alu_res;
            WD_MEM:  grf_wd = mem_ext;
            WD_PC8:  grf_wd = pc8;
            WD_HILO: grf_wd = w_q.hilo;
            WD_CP0:  grf_wd = w_q.cp0_rdata;
            default: grf_wd = w_q.alu_res;
        endcase
    end

    assign grf_a3 = w_valid ? w_q.a3 : 5'd0;
    assign w_pc   = w_q.pc;

endmodule

// File: tb/tb_w_stage.sv
// Directed bench for w_stage with a default-width and a 4-bit retire counter instance.
// Inputs change 1 time unit after the rising edge; outputs are checked just after that.
// No backpressure exists in the design; the bench simply steps one edge per vector.
module tb_w_stage;
    import w_pkg::*;

    logic        clk;
    logic        reset;
    logic        m_valid;
    logic        m_flush;
    logic [31:0] m_pc;
    logic [4:0]  m_a3;
    logic [2:0]  m_wd_sel;
    logic [2:0]  m_load_type;
    logic [1:0]  m_addr_lo;
    logic [31:0] m_alu_res;
    logic [31:0] m_mem_rdata;
    logic [31:0] m_hilo;
    logic [31:0] m_cp0_rdata;

    logic [4:0]  grf_a3,  grf_a3_4;
    logic [31:0] grf_wd,  grf_wd_4;
    logic        w_valid, w_valid_4;
    logic [31:0] w_pc,    w_pc_4;
    logic [31:0] retire_cnt;
    logic [3:0]  retire_cnt_4;

    int n_checks;
    int n_fail;

    // Small reference model of the retire counter and W occupancy
    logic        exp_wv;
    logic [31:0] exp_cnt;

    w_stage dut (
        .clk(clk), .reset(reset), .m_valid(m_valid), .m_flush(m_flush), .m_pc(m_pc),
        .m_a3(m_a3), .m_wd_sel(m_wd_sel), .m_load_type(m_load_type), .m_addr_lo(m_addr_lo),
        .m_alu_res(m_alu_res), .m_mem_rdata(m_mem_rdata), .m_hilo(m_hilo),
        .m_cp0_rdata(m_cp0_rdata), .grf_a3(grf_a3), .grf_wd(grf_wd), .w_valid(w_valid),
        .w_pc(w_pc), .retire_cnt(retire_cnt)
    );

    w_stage #(.RETIRE_W(4)) dut4 (
        .clk(clk), .reset(reset), .m_valid(m_valid), .m_flush(m_flush), .m_pc(m_pc),
        .m_a3(m_a3), .m_wd_sel(m_wd_sel), .m_load_type(m_load_type), .m_addr_lo(m_addr_lo),
        .m_alu_res(m_alu_res), .m_mem_rdata(m_mem_rdata), .m_hilo(m_hilo),
        .m_cp0_rdata(m_cp0_rdata), .grf_a3(grf_a3_4), .grf_wd(grf_wd_4), .w_valid(w_valid_4),
        .w_pc(w_pc_4), .retire_cnt(retire_cnt_4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge, updating the model from the inputs presented before it
    task automatic step();
        if (exp_wv && !reset) exp_cnt = exp_cnt + 32'd1;
        if (reset) exp_cnt = 32'd0;
        exp_wv = m_valid && !m_flush && !reset;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m_valid = 1'b0; m_flush = 1'b0; m_a3 = 5'd0;
    endtask

    task automatic issue(input logic [4:0] a3, input logic [2:0] sel, input logic [31:0] pc);
        m_valid = 1'b1; m_flush = 1'b0; m_a3 = a3; m_wd_sel = sel; m_pc = pc;
    endtask

    // Load sweep vectors over rdata 0x80FF7F01
    logic [2:0]  ld_type [10];
    logic [1:0]  ld_addr [10];
    logic [31:0] ld_exp  [10];

    initial begin
        n_checks = 0; n_fail = 0;
        exp_wv = 1'b0; exp_cnt = 32'd0;
        reset = 1'b1;
        idle();
        m_pc = 32'd0; m_wd_sel = WD_ALU; m_load_type = LOAD_LW; m_addr_lo = 2'd0;
        m_alu_res = 32'd0; m_mem_rdata = 32'd0; m_hilo = 32'hCAFEBABE; m_cp0_rdata = 32'h0BADF00D;

        ld_type[0] = LOAD_LB;  ld_addr[0] = 2'd0; ld_exp[0] = 32'h00000001;
        ld_type[1] = LOAD_LB;  ld_addr[1] = 2'd1; ld_exp[1] = 32'h0000007F;
        ld_type[2] = LOAD_LB;  ld_addr[2] = 2'd2; ld_exp[2] = 32'hFFFFFFFF;
        ld_type[3] = LOAD_LBU; ld_addr[3] = 2'd3; ld_exp[3] = 32'h00000080;
        ld_type[4] = LOAD_LH;  ld_addr[4] = 2'd0; ld_exp[4] = 32'h00007F01;
        ld_type[5] = LOAD_LH;  ld_addr[5] = 2'd2; ld_exp[5] = 32'hFFFF80FF;
        ld_type[6] = LOAD_LHU; ld_addr[6] = 2'd2; ld_exp[6] = 32'h000080FF;
        ld_type[7] = LOAD_LW;  ld_addr[7] = 2'd0; ld_exp[7] = 32'h80FF7F01;
        ld_type[8] = LOAD_LB;  ld_addr[8] = 2'd3; ld_exp[8] = 32'hFFFFFF80;
        ld_type[9] = 3'd5;     ld_addr[9] = 2'd1; ld_exp[9] = 32'h80FF7F01;

        // Reset for two cycles, then idle
        step(); step();
        reset = 1'b0;
        step();
        check("reset grf_a3", {27'd0, grf_a3}, 32'd0);
        check("reset grf_wd", grf_wd, 32'd0);
        check("reset w_valid", {31'd0, w_valid}, 32'd0);
        check("reset w_pc", w_pc, 32'd0);
        check("reset retire_cnt", retire_cnt, 32'd0);
        check("reset retire_cnt4", {28'd0, retire_cnt_4}, 32'd0);

        // Single ALU instruction
        issue(5'd8, WD_ALU, 32'h00001000);
        m_alu_res = 32'h12345678;
        step();
        check("alu grf_a3", {27'd0, grf_a3}, 32'd8);
        check("alu grf_wd", grf_wd, 32'h12345678);
        check("alu w_valid", {31'd0, w_valid}, 32'd1);
        check("alu w_pc", w_pc, 32'h00001000);
        check("alu cnt before retire", retire_cnt, 32'd0);
        idle();
        step();
        check("alu cnt after retire", retire_cnt, 32'd1);
        check("idle grf_a3", {27'd0, grf_a3}, 32'd0);
        check("idle w_valid", {31'd0, w_valid}, 32'd0);

        // Load extension sweep, back to back
        m_mem_rdata = 32'h80FF7F01;
        for (int i = 0; i < 10; i++) begin
            issue(5'd9, WD_MEM, 32'h00002000 + 32'(4 * i));
            m_load_type = ld_type[i];
            m_addr_lo = ld_addr[i];
            step();
            check($sformatf("load%0d grf_wd", i), grf_wd, ld_exp[i]);
            check($sformatf("load%0d grf_a3", i), {27'd0, grf_a3}, 32'd9);
        end

        // Other sources and an unused select code
        issue(5'd10, WD_HILO, 32'h00002100);
        step();
        check("hilo grf_wd", grf_wd, 32'hCAFEBABE);
        issue(5'd11, WD_CP0, 32'h00002104);
        step();
        check("cp0 grf_wd", grf_wd, 32'h0BADF00D);
        issue(5'd12, 3'd6, 32'h00002108);
        m_alu_res = 32'hA5A55A5A;
        step();
        check("sel6 grf_wd", grf_wd, 32'hA5A55A5A);

        // PC+8 including wraparound
        issue(5'd31, WD_PC8, 32'h00003000);
        step();
        check("pc8 grf_wd", grf_wd, 32'h00003008);
        check("pc8 grf_a3", {27'd0, grf_a3}, 32'd31);
        issue(5'd31, WD_PC8, 32'hFFFFFFFC);
        step();
        check("pc8 wrap grf_wd", grf_wd, 32'h00000004);
        idle();
        step();
        check("cnt after run", retire_cnt, exp_cnt);

        // Flush beats valid
        issue(5'd5, WD_ALU, 32'h00004000);
        m_flush = 1'b1;
        step();
        check("flush grf_a3", {27'd0, grf_a3}, 32'd0);
        check("flush w_valid", {31'd0, w_valid}, 32'd0);
        idle();
        step();
        check("flush cnt unchanged", retire_cnt, exp_cnt);

        // Reset while W holds a live instruction
        issue(5'd7, WD_ALU, 32'h00005000);
        step();
        check("pre-reset w_valid", {31'd0, w_valid}, 32'd1);
        issue(5'd6, WD_ALU, 32'h00005004);
        reset = 1'b1;
        step();
        check("mid reset grf_a3", {27'd0, grf_a3}, 32'd0);
        check("mid reset w_valid", {31'd0, w_valid}, 32'd0);
        check("mid reset cnt", retire_cnt, 32'd0);
        reset = 1'b0;
        idle();
        step();
        check("post reset cnt", retire_cnt, 32'd0);
        check("post reset grf_a3", {27'd0, grf_a3}, 32'd0);

        // 17 back-to-back retirements; the 4-bit counter wraps to 1
        for (int i = 0; i < 17; i++) begin
            issue(5'd1, WD_ALU, 32'h00006000 + 32'(4 * i));
            step();
        end
        idle();
        step();
        check("retire 17 wide", retire_cnt, 32'd17);
        check("retire 17 narrow", {28'd0, retire_cnt_4}, 32'd1);
        check("retire model", retire_cnt, exp_cnt);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
